conv_encoder_k3: RTL and testbench
==================================

CONV_ENCODER_K3 -- requirements
Module: conv_encoder_k3

Interface
REQ-001 The module SHALL have parameter G0, default 3'b111, giving the generator taps {u, s1, s0} for symbol bit 1.
REQ-002 The module SHALL have parameter G1, default 3'b101, giving the generator taps {u, s1, s0} for symbol bit 0.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port data_in, input, 8 bits: the information byte, encoded MSB first.
REQ-006 The module SHALL have port data_valid, input, 1 bit: data_in is valid.
REQ-007 The module SHALL have port data_ready, output, 1 bit: the encoder accepts a byte this cycle.
REQ-008 The module SHALL have port sym_out, output, 2 bits: the coded symbol, with bit 1 from G0 and bit 0 from G1.
REQ-009 The module SHALL have port sym_valid, output, 1 bit: sym_out is valid.
REQ-010 The module SHALL have port sym_ready, input, 1 bit: the downstream decoder accepts the symbol.
REQ-011 The module SHALL have port frame_done, output, 1 bit: a one-cycle pulse when the last symbol of a frame is accepted.

Function
REQ-012 The encoder SHALL be rate 1/2, K=3, with a 2-bit shift register {s1, s0}, where s1 = u(t-1) and s0 = u(t-2).
REQ-013 Each symbol bit SHALL equal the XOR-reduction of {u, s1, s0} ANDed with the corresponding generator.
REQ-014 The FSM SHALL have the states IDLE, ENCODE and TAIL.
REQ-015 In IDLE, data_ready SHALL be 1; in ENCODE and TAIL, data_ready SHALL be 0.
REQ-016 A byte SHALL be accepted when data_valid and data_ready are both 1; the byte is then latched and the state becomes ENCODE with a 3-bit bit index of 7.
REQ-017 Latency: the first symbol SHALL present sym_valid=1 on the cycle after acceptance; sym_out and sym_valid SHALL be registered.
REQ-018 A symbol SHALL complete when sym_valid and sym_ready are both 1.
  - On completion, the shift register SHALL shift: s1 <= u, s0 <= s1.
  - On completion, the bit index SHALL decrement and the next symbol SHALL be presented on the following cycle with no bubble.
REQ-019 While sym_valid=1 and sym_ready=0, sym_out, the shift register and the bit index SHALL hold stable.
REQ-020 Completion of the bit-index-0 symbol SHALL end the ENCODE phase.
  - Next state is TAIL when the tail feature is compiled in (REQ-026).
  - Otherwise next state is IDLE and frame_done pulses.
REQ-021 In TAIL, two symbols with u=0 SHALL be emitted under the same handshake.
  - Completion of the second tail symbol SHALL pulse frame_done, leave {s1, s0}=2'b00, and return to IDLE.
REQ-022 In IDLE, sym_valid SHALL be 0 and sym_out SHALL be 2'b00.
REQ-023 data_valid asserted outside IDLE SHALL be ignored; no byte is lost, because data_ready=0.
REQ-024 A frame SHALL take at least 8 symbol cycles (10 with tail) plus 1 acceptance cycle; back-to-back frames SHALL incur exactly one IDLE cycle between them.

Reset
REQ-025 While rst=1 at a clock edge, all of the following SHALL hold, overriding any handshake in progress:
  - state <= IDLE
  - {s1, s0} <= 2'b00
  - bit index <= 0
  - sym_out <= 2'b00
  - sym_valid <= 0
  - frame_done <= 0
  - data_ready SHALL be 1 on the first cycle after rst deasserts.
  - A mid-frame reset SHALL discard the remainder of the frame.

Configuration
REQ-026 Macro TAIL_FLUSH_EN SHALL control tail flushing.
  - Defined: the TAIL state exists, 2 zero tail symbols are appended per frame, and every frame starts from state 00.
  - Undefined: the TAIL state is absent, frames are 8 symbols, and {s1, s0} carries over between frames (continuous stream); it is cleared only by reset.

Verification
REQ-027 Reset, then data_in=8'hB0 with sym_ready held 1 -> sym_out sequence 11,10,00,01,01,11,00,00; with TAIL_FLUSH_EN the sequence continues 00,00; frame_done pulses with the last symbol.
REQ-028 Backpressure: frame 8'hB0 with sym_ready low on alternate cycles -> same symbol sequence, each symbol held stable while sym_ready=0, and no symbol skipped or repeated.
REQ-029 Back-to-back frames 8'hFF then 8'h00:
  - First symbol of frame 2 is 00 with TAIL_FLUSH_EN.
  - First symbol of frame 2 is 01 without TAIL_FLUSH_EN (state 11 carried over).
REQ-030 data_valid held 1 during a frame -> data_ready=0 until IDLE, and exactly one byte is accepted per frame.
REQ-031 rst asserted at the 4th symbol of a frame -> next cycle sym_valid=0, data_ready=1, state 00; a new frame 8'h80 yields 11,10,11,00,...
REQ-032 Idle with data_valid=0 for 20 cycles -> sym_valid stays 0, frame_done stays 0, and data_ready stays 1.

Source files
------------

// File: rtl/conv_encoder_k3.sv
// conv_encoder_k3: rate-1/2, K=3 convolutional encoder with byte input,
// valid/ready symbol output and optional zero-tail flushing.
//
// Parameters:
//   G0, G1     generator taps {u, s1, s0} for sym_out[1] and sym_out[0]
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   data_in    information byte, encoded MSB first
//   data_valid data_in valid
//   data_ready encoder idle and able to take a byte
//   sym_out    coded symbol {G0 bit, G1 bit}, registered
//   sym_valid  sym_out valid, registered
//   sym_ready  downstream accepts the symbol
//   frame_done one-cycle pulse after the last symbol of a frame completes
// Configuration:
//   TAIL_FLUSH_EN  defined: two zero tail symbols flush the register
//                  after every byte; undefined: register state carries
//                  over between frames (continuous stream).
module conv_encoder_k3 #(
   parameter logic [2:0] G0 = 3'b111,
   parameter logic [2:0] G1 = 3'b101
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       data_ready,
   output logic [1:0] sym_out,
   output logic       sym_valid,
   input  logic       sym_ready,
   output logic       frame_done
);

`ifdef TAIL_FLUSH_EN
   typedef enum logic [1:0] {IDLE, ENCODE, TAIL} state_t;
`else
   typedef enum logic [1:0] {IDLE, ENCODE} state_t;
`endif

   state_t      state_q;
   logic [7:0]  data_q;
   logic [2:0]  idx_q;
   logic [1:0]  sreg_q;
   logic [1:0]  sym_q;
   logic        symv_q;
   logic        done_q;

   logic        sym_fire;
   logic        u_now;
   logic        u_next;
   logic [2:0]  idx_m1;
   logic [1:0]  sreg_d;

   function automatic logic [1:0] enc(input logic u, input logic [1:0] s);
      logic [2:0] v;
      v = {u, s};
      return {^(v & G0), ^(v & G1)};
   endfunction

   // The symbol is registered, so when one symbol completes the next one
   // is built from the post-shift register contents (sreg_d).
   always_comb begin
      sym_fire = symv_q & sym_ready;
      u_now    = (state_q == ENCODE) ? data_q[idx_q] : 1'b0;
      idx_m1   = idx_q - 3'd1;
      u_next   = data_q[idx_m1];
      sreg_d   = {u_now, sreg_q[1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= 8'h00;
         idx_q   <= 3'd0;
         sreg_q  <= 2'b00;
         sym_q   <= 2'b00;
         symv_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (data_valid) begin
                  data_q  <= data_in;
                  idx_q   <= 3'd7;
                  sym_q   <= enc(data_in[7], sreg_q);
                  symv_q  <= 1'b1;
                  state_q <= ENCODE;
               end
            end
            ENCODE: begin
               if (sym_fire) begin
                  sreg_q <= sreg_d;
                  if (idx_q != 3'd0) begin
                     idx_q <= idx_m1;
                     sym_q <= enc(u_next, sreg_d);
                  end else begin
`ifdef TAIL_FLUSH_EN
                     // idx_q counts the remaining tail symbols
                     idx_q   <= 3'd1;
                     sym_q   <= enc(1'b0, sreg_d);
                     state_q <= TAIL;
`else
                     sym_q   <= 2'b00;
                     symv_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
`endif
                  end
               end
            end
`ifdef TAIL_FLUSH_EN
            TAIL: begin
               if (sym_fire) begin
                  sreg_q <= sreg_d;
                  if (idx_q != 3'd0) begin
                     idx_q <= 3'd0;
                     sym_q <= enc(1'b0, sreg_d);
                  end else begin
                     sym_q   <= 2'b00;
                     symv_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end
               end
            end
`endif
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign data_ready = (state_q == IDLE);
   assign sym_out    = sym_q;
   assign sym_valid  = symv_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_conv_encoder_k3.sv
// tb_conv_encoder_k3: scoreboard bench for conv_encoder_k3.
// Adapts expected tail behaviour to TAIL_FLUSH_EN.
module tb_conv_encoder_k3;

   localparam logic [2:0] TG0 = 3'b111;
   localparam logic [2:0] TG1 = 3'b101;

   logic       clk;
   logic       rst;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;
   logic [1:0] sym_out;
   logic       sym_valid;
   logic       sym_ready;
   logic       frame_done;

   int checks;
   int errors;

   logic [1:0] exp_q[$];
   logic [1:0] got_q[$];
   logic       m1;
   logic       m0;

   conv_encoder_k3 #(.G0(TG0), .G1(TG1)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .sym_out    (sym_out),
      .sym_valid  (sym_valid),
      .sym_ready  (sym_ready),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: textbook shift-register convolution
   function automatic logic [1:0] model_sym(input logic u, input logic a,
                                            input logic b);
      logic x1;
      logic x0;
      x1 = (TG0[2] & u) ^ (TG0[1] & a) ^ (TG0[0] & b);
      x0 = (TG1[2] & u) ^ (TG1[1] & a) ^ (TG1[0] & b);
      return {x1, x0};
   endfunction

   task automatic push_bit(input logic u);
      exp_q.push_back(model_sym(u, m1, m0));
      m0 = m1;
      m1 = u;
   endtask

   task automatic push_frame(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) push_bit(b[i]);
`ifdef TAIL_FLUSH_EN
      push_bit(1'b0);
      push_bit(1'b0);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Entered and left at a negedge with the DUT idle.
   task automatic drive_frame(input logic [7:0] b, input bit bp,
                              input bit hold_dv);
      int  cyc;
      bit  done;
      checks++;
      if (data_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_before_frame got %b want 1", data_ready);
      end
      got_q.delete();
      data_in    = b;
      data_valid = 1'b1;
      sym_ready  = 1'b1;
      push_frame(b);
      tick();
      if (hold_dv) data_in = ~b;
      else data_valid = 1'b0;
      done = 0;
      cyc  = 0;
      while (!done && cyc < 200) begin
         checks++;
         if (data_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_busy cyc %0d got %b want 0", cyc, data_ready);
         end
         checks++;
         if (sym_valid !== 1'b1) begin
            errors++;
            $display("FAIL sym_valid cyc %0d got %b want 1", cyc, sym_valid);
         end
         checks++;
         if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL early_done cyc %0d got %b want 0", cyc, frame_done);
         end
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL queue_empty cyc %0d got symbol want none", cyc);
            done = 1;
         end else begin
            checks++;
            if (sym_out !== exp_q[0]) begin
               errors++;
               $display("FAIL sym_out cyc %0d got %b want %b",
                        cyc, sym_out, exp_q[0]);
            end
            sym_ready = bp ? (cyc % 2 == 1) : 1'b1;
            if (sym_ready && sym_valid) begin
               got_q.push_back(sym_out);
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) done = 1;
            end
         end
         tick();
         cyc++;
      end
      if (!done) begin
         errors++;
         $display("FAIL frame_timeout got %0d left want 0", exp_q.size());
      end
      data_valid = 1'b0;
      checks++;
      if (frame_done !== 1'b1) begin
         errors++;
         $display("FAIL frame_done got %b want 1", frame_done);
      end
      checks++;
      if (sym_valid !== 1'b0 || sym_out !== 2'b00) begin
         errors++;
         $display("FAIL end_idle got v=%b s=%b want v=0 s=00",
                  sym_valid, sym_out);
      end
      checks++;
      if (data_ready !== 1'b1) begin
         errors++;
         $display("FAIL end_ready got %b want 1", data_ready);
      end
   endtask

   task automatic check_b0_seq(input string tag);
      logic [1:0] ref_s[$];
      ref_s = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00};
`ifdef TAIL_FLUSH_EN
      ref_s.push_back(2'b00);
      ref_s.push_back(2'b00);
`endif
      checks++;
      if (got_q.size() != ref_s.size()) begin
         errors++;
         $display("FAIL %s_len got %0d want %0d", tag, got_q.size(),
                  ref_s.size());
      end else begin
         for (int i = 0; i < ref_s.size(); i++) begin
            checks++;
            if (got_q[i] !== ref_s[i]) begin
               errors++;
               $display("FAIL %s_sym%0d got %b want %b", tag, i,
                        got_q[i], ref_s[i]);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      data_in    = 8'h00;
      data_valid = 1'b0;
      sym_ready  = 1'b0;
      m1 = 1'b0;
      m0 = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      checks++;
      if (sym_valid !== 1'b0 || sym_out !== 2'b00 || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_out got v=%b s=%b d=%b want 0 00 0",
                  sym_valid, sym_out, frame_done);
      end
      checks++;
      if (data_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b want 1", data_ready);
      end
   endtask

   task automatic test_basic();
      drive_frame(8'hB0, 1'b0, 1'b0);
      check_b0_seq("basic");
   endtask

   task automatic test_backpressure();
      tick();
      drive_frame(8'hB0, 1'b1, 1'b0);
      check_b0_seq("bp");
   endtask

   task automatic test_back_to_back();
      logic [1:0] want;
`ifdef TAIL_FLUSH_EN
      want = 2'b00;
`else
      want = 2'b01;
`endif
      tick();
      drive_frame(8'hFF, 1'b0, 1'b0);
      drive_frame(8'h00, 1'b0, 1'b0);
      checks++;
      if (got_q.size() == 0 || got_q[0] !== want) begin
         errors++;
         $display("FAIL b2b_first got %b want %b",
                  (got_q.size() != 0) ? got_q[0] : 2'bxx, want);
      end
   endtask

   task automatic test_hold_valid();
      tick();
      drive_frame(8'h5A, 1'b0, 1'b1);
      tick();
      checks++;
      if (sym_valid !== 1'b0 || data_ready !== 1'b1) begin
         errors++;
         $display("FAIL hold_extra got v=%b r=%b want v=0 r=1",
                  sym_valid, data_ready);
      end
   endtask

   task automatic test_mid_reset();
      int n;
      logic [1:0] ref_s[$];
      tick();
      data_in    = 8'hFF;
      data_valid = 1'b1;
      sym_ready  = 1'b1;
      tick();
      data_valid = 1'b0;
      n = 0;
      while (n < 3) begin
         if (sym_valid) n++;
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      m1 = 1'b0;
      m0 = 1'b0;
      checks++;
      if (sym_valid !== 1'b0 || data_ready !== 1'b1 || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL midrst got v=%b r=%b d=%b want 0 1 0",
                  sym_valid, data_ready, frame_done);
      end
      drive_frame(8'h80, 1'b0, 1'b0);
      ref_s = '{2'b11, 2'b10, 2'b11, 2'b00};
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (got_q.size() <= i || got_q[i] !== ref_s[i]) begin
            errors++;
            $display("FAIL midrst_sym%0d got %b want %b", i,
                     (got_q.size() > i) ? got_q[i] : 2'bxx, ref_s[i]);
         end
      end
   endtask

   task automatic test_idle();
      data_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (sym_valid !== 1'b0 || frame_done !== 1'b0 || data_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle cyc %0d got v=%b d=%b r=%b want 0 0 1",
                     i, sym_valid, frame_done, data_ready);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_hold_valid();
      test_mid_reset();
      test_idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
